ex_mem_resolve_stage: RTL and testbench

- EX/MEM pipeline stage that consumes the ALU result and flags (r, cf, zf, vf, sf) and registers them for the memory stage.
- Resolves conditional branches from the flags, computes jump/branch targets and link values, and issues a one-cycle redirect.
- Squashes the wrong-path instructions that follow a taken control transfer.
- Sits between the execute stage (upstream valid/ready) and the memory stage (downstream valid/ready).

---
 rtl/ex_mem_resolve_stage_pkg.sv | 23 ++
 rtl/ex_mem_resolve_stage_branch_cond.sv | 30 +++
 rtl/ex_mem_resolve_stage.sv | 179 +++++++++++++++++
 tb/tb_ex_mem_resolve_stage.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_mem_resolve_stage_pkg.sv
// Shared definitions for the EX/MEM resolve stage: branch condition codes,
// squash state encoding and the default datapath width.
package ex_mem_resolve_stage_pkg;

    localparam int XLEN_DEF = 32;

    // funct3 encodings of the conditional branches
    localparam logic [2:0] BR_BEQ  = 3'b000;
    localparam logic [2:0] BR_BNE  = 3'b001;
    localparam logic [2:0] BR_RSV2 = 3'b010;
    localparam logic [2:0] BR_RSV3 = 3'b011;
    localparam logic [2:0] BR_BLT  = 3'b100;
    localparam logic [2:0] BR_BGE  = 3'b101;
    localparam logic [2:0] BR_BLTU = 3'b110;
    localparam logic [2:0] BR_BGEU = 3'b111;

    // RUN: instructions flow normally; SQUASH: wrong-path instructions are dropped
    typedef enum logic {
        RUN    = 1'b0,
        SQUASH = 1'b1
    } squash_state_t;

endpackage

// File: rtl/ex_mem_resolve_stage_branch_cond.sv
// Branch condition evaluation from the flags of rs1 - rs2.
// cf is the no-borrow carry, so cf=1 means rs1 >= rs2 unsigned.
module ex_mem_resolve_stage_branch_cond
    import ex_mem_resolve_stage_pkg::*;
(
    input  logic       cf,
    input  logic       zf,
    input  logic       vf,
    input  logic       sf,
    input  logic [2:0] funct3,
    output logic       taken,
    output logic       illegal
);

    // Select the condition; reserved encodings are never taken and flag illegal
    always_comb begin
        taken   = 1'b0;
        illegal = 1'b0;
        case (funct3)
            BR_BEQ:  taken = zf;
            BR_BNE:  taken = ~zf;
            BR_BLT:  taken = (sf != vf);
            BR_BGE:  taken = (sf == vf);
            BR_BLTU: taken = ~cf;
            BR_BGEU: taken = cf;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/ex_mem_resolve_stage.sv
// EX/MEM pipeline stage: registers the ALU result for the memory stage,
// resolves branches/jumps, pulses a one-cycle redirect and squashes the
// wrong-path instructions that follow a taken control transfer.
//
// Handshake: a transfer happens on a rising edge where valid & ready are
// both high. Upstream: in_ready = ~out_valid | out_ready, an instruction is
// accepted when in_valid & in_ready & ~flush_in. Downstream: out_valid and
// all out_* stay stable while out_valid & ~out_ready.
module ex_mem_resolve_stage
    import ex_mem_resolve_stage_pkg::*;
#(
    parameter int XLEN         = XLEN_DEF,
    parameter int SQUASH_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] alu_r,
    input  logic            alu_cf,
    input  logic            alu_zf,
    input  logic            alu_vf,
    input  logic            alu_sf,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] imm,
    input  logic [2:0]      funct3,
    input  logic            is_branch,
    input  logic            is_jal,
    input  logic            is_jalr,
    input  logic [4:0]      rd,
    input  logic            reg_write,
    input  logic            mem_read,
    input  logic            mem_write,
    input  logic [XLEN-1:0] store_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic [XLEN-1:0] out_store_data,
    output logic [4:0]      out_rd,
    output logic            out_reg_write,
    output logic            out_mem_read,
    output logic            out_mem_write,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    output logic            illegal_branch,
    input  logic            flush_in,
    output squash_state_t   dbg_state,
    output logic [2:0]      dbg_cnt
);

    localparam logic [2:0] SQUASH_LOAD = 3'(SQUASH_DEPTH);

    squash_state_t   state;
    squash_state_t   state_next;
    logic [2:0]      cnt;
    logic [2:0]      cnt_next;

    logic            accept;
    logic            pass;
    logic            cond_taken;
    logic            cond_illegal;
    logic            taken;
    logic            illegal_now;
    logic [XLEN-1:0] link;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] result;
    logic            reg_write_q;
    logic            mem_read_q;
    logic            mem_write_q;

    assign in_ready = ~out_valid | out_ready;
    assign accept   = in_valid & in_ready & ~flush_in;

    ex_mem_resolve_stage_branch_cond u_branch_cond (
        .cf      (alu_cf),
        .zf      (alu_zf),
        .vf      (alu_vf),
        .sf      (alu_sf),
        .funct3  (funct3),
        .taken   (cond_taken),
        .illegal (cond_illegal)
    );

    assign taken       = is_jal | is_jalr | (is_branch & cond_taken);
    assign illegal_now = is_branch & cond_illegal;
    assign link        = pc + XLEN'(4);
    assign target      = is_jalr ? {alu_r[XLEN-1:1], 1'b0} : (pc + imm);
    assign result      = (is_jal | is_jalr) ? link : alu_r;

    // Squash FSM state and discard counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= RUN;
            cnt   <= 3'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Squash FSM next state: flush wins, otherwise only accepts advance it
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        if (flush_in) begin
            state_next = RUN;
            cnt_next   = 3'd0;
        end else if (accept) begin
            case (state)
                RUN: begin
                    if (taken && (SQUASH_DEPTH != 0)) begin
                        state_next = SQUASH;
                        cnt_next   = SQUASH_LOAD;
                    end
                end
                SQUASH: begin
                    if (cnt <= 3'd1) begin
                        state_next = RUN;
                        cnt_next   = 3'd0;
                    end else begin
                        cnt_next = cnt - 3'd1;
                    end
                end
            endcase
        end
    end

    // Squash FSM outputs: only accepts seen in RUN reach the output register
    always_comb begin
        pass      = accept & (state == RUN);
        dbg_state = state;
        dbg_cnt   = cnt;
    end

    // Output register, redirect and illegal pulses
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid      <= 1'b0;
            out_result     <= '0;
            out_store_data <= '0;
            out_rd         <= 5'd0;
            reg_write_q    <= 1'b0;
            mem_read_q     <= 1'b0;
            mem_write_q    <= 1'b0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            illegal_branch <= 1'b0;
        end else if (flush_in) begin
            out_valid      <= 1'b0;
            redirect_valid <= 1'b0;
            illegal_branch <= 1'b0;
        end else begin
            redirect_valid <= 1'b0;
            illegal_branch <= 1'b0;
            if (pass) begin
                out_valid      <= 1'b1;
                out_result     <= result;
                out_store_data <= store_data;
                out_rd         <= rd;
                reg_write_q    <= reg_write & ~illegal_now;
                mem_read_q     <= mem_read;
                mem_write_q    <= mem_write;
                illegal_branch <= illegal_now;
                if (taken) begin
                    redirect_valid <= 1'b1;
                    redirect_pc    <= target;
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    // Control bits never leak out while the stage holds no instruction
    assign out_reg_write = reg_write_q & out_valid;
    assign out_mem_read  = mem_read_q & out_valid;
    assign out_mem_write = mem_write_q & out_valid;

endmodule

// File: tb/tb_ex_mem_resolve_stage.sv
// Bench for ex_mem_resolve_stage: directed scenarios followed by random
// traffic, checked against a transaction-level model (single-entry buffer
// plus a count of instructions still to be skipped).
module tb_ex_mem_resolve_stage;
    import ex_mem_resolve_stage_pkg::*;

    localparam int XLEN  = 32;
    localparam int DEPTH = 2;
    localparam int W     = 72;

    logic            clk;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] alu_r;
    logic            alu_cf, alu_zf, alu_vf, alu_sf;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    logic [2:0]      funct3;
    logic            is_branch, is_jal, is_jalr;
    logic [4:0]      rd;
    logic            reg_write, mem_read, mem_write;
    logic [XLEN-1:0] store_data;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_result;
    logic [XLEN-1:0] out_store_data;
    logic [4:0]      out_rd;
    logic            out_reg_write, out_mem_read, out_mem_write;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            illegal_branch;
    logic            flush_in;
    squash_state_t   dbg_state;
    logic [2:0]      dbg_cnt;

    ex_mem_resolve_stage #(.XLEN(XLEN), .SQUASH_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .alu_r(alu_r), .alu_cf(alu_cf), .alu_zf(alu_zf), .alu_vf(alu_vf), .alu_sf(alu_sf),
        .pc(pc), .imm(imm), .funct3(funct3),
        .is_branch(is_branch), .is_jal(is_jal), .is_jalr(is_jalr),
        .rd(rd), .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
        .store_data(store_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_store_data(out_store_data), .out_rd(out_rd),
        .out_reg_write(out_reg_write), .out_mem_read(out_mem_read), .out_mem_write(out_mem_write),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .illegal_branch(illegal_branch), .flush_in(flush_in),
        .dbg_state(dbg_state), .dbg_cnt(dbg_cnt)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // scoreboard and model state
    logic [W-1:0] exp_q[$];
    int           skip;
    logic         exp_redirect;
    logic         exp_illegal;
    logic [31:0]  exp_rpc;
    int           n_checks;
    int           n_fail;

    // next instruction to present (architectural operands, not flags only)
    logic [31:0] n_pc, n_imm, n_alu, n_rs1, n_rs2, n_store;
    logic [2:0]  n_f3;
    logic        n_br, n_jal, n_jalr;
    logic [4:0]  n_rd;
    logic        n_rw, n_mr, n_mw;
    logic        n_cf, n_zf, n_vf, n_sf;

    task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // driver helpers: build the next instruction
    task automatic set_common();
        n_rd    = 5'($urandom);
        n_rw    = 1'($urandom);
        n_store = $urandom;
        n_mr    = 1'b0;
        n_mw    = 1'b0;
        n_br    = 1'b0;
        n_jal   = 1'b0;
        n_jalr  = 1'b0;
        n_f3    = 3'($urandom);
        n_pc    = {$urandom, 2'b00} >> 0;
        n_imm   = $urandom;
        n_rs1   = 32'd0;
        n_rs2   = 32'd0;
    endtask

    task automatic set_branch(input logic [31:0] pc_v, input logic [31:0] imm_v,
                              input logic [31:0] rs1_v, input logic [31:0] rs2_v,
                              input logic [2:0] f3);
        logic [31:0] diff;
        set_common();
        diff  = rs1_v - rs2_v;
        n_br  = 1'b1;
        n_f3  = f3;
        n_pc  = pc_v;
        n_imm = imm_v;
        n_rs1 = rs1_v;
        n_rs2 = rs2_v;
        n_alu = diff;
        n_zf  = (rs1_v == rs2_v);
        n_cf  = (rs1_v >= rs2_v);
        n_sf  = diff[31];
        n_vf  = (rs1_v[31] != rs2_v[31]) && (diff[31] != rs1_v[31]);
    endtask

    task automatic set_jal(input logic [31:0] pc_v, input logic [31:0] imm_v);
        set_common();
        n_jal = 1'b1;
        n_rw  = 1'b1;
        n_pc  = pc_v;
        n_imm = imm_v;
        n_alu = $urandom;
        {n_cf, n_zf, n_vf, n_sf} = 4'($urandom);
    endtask

    task automatic set_jalr(input logic [31:0] pc_v, input logic [31:0] alu_v);
        set_common();
        n_jalr = 1'b1;
        n_rw   = 1'b1;
        n_pc   = pc_v;
        n_alu  = alu_v;
        {n_cf, n_zf, n_vf, n_sf} = 4'($urandom);
    endtask

    task automatic set_alu(input logic [31:0] alu_v);
        set_common();
        n_alu = alu_v;
        n_mr  = 1'($urandom);
        n_mw  = ~n_mr & 1'($urandom);
        {n_cf, n_zf, n_vf, n_sf} = 4'($urandom);
    endtask

    // reference rules, written on operands rather than flags
    function automatic logic ref_illegal();
        return n_br && (n_f3 == 3'b010 || n_f3 == 3'b011);
    endfunction

    function automatic logic ref_taken();
        if (n_jal || n_jalr) return 1'b1;
        if (!n_br) return 1'b0;
        case (n_f3)
            3'b000:  return n_rs1 == n_rs2;
            3'b001:  return n_rs1 != n_rs2;
            3'b100:  return $signed(n_rs1) < $signed(n_rs2);
            3'b101:  return $signed(n_rs1) >= $signed(n_rs2);
            3'b110:  return n_rs1 < n_rs2;
            3'b111:  return n_rs1 >= n_rs2;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [W-1:0] ref_word();
        logic [31:0] res;
        res = (n_jal || n_jalr) ? n_pc + 32'd4 : n_alu;
        return {res, n_store, n_rd, n_rw & ~ref_illegal(), n_mr, n_mw};
    endfunction

    function automatic logic [31:0] ref_target();
        return n_jalr ? (n_alu & ~32'd1) : n_pc + n_imm;
    endfunction

    task automatic check_outputs();
        check_eq("out_valid", W'(out_valid), W'(exp_q.size() != 0));
        if (exp_q.size() != 0)
            check_eq("out_word", {out_result, out_store_data, out_rd, out_reg_write, out_mem_read, out_mem_write}, exp_q[0]);
        else
            check_eq("ctl_idle", W'({out_reg_write, out_mem_read, out_mem_write}), W'(0));
        check_eq("redirect_valid", W'(redirect_valid), W'(exp_redirect));
        check_eq("redirect_pc", W'(redirect_pc), W'(exp_rpc));
        check_eq("illegal_branch", W'(illegal_branch), W'(exp_illegal));
        check_eq("squash_cnt", W'(dbg_cnt), W'(skip));
    endtask

    // one clock: check previous edge, present inputs, advance the model
    task automatic cycle(input bit iv, input bit ordy, input bit fl);
        logic rdy_exp;
        @(negedge clk);
        check_outputs();
        alu_r = n_alu; alu_cf = n_cf; alu_zf = n_zf; alu_vf = n_vf; alu_sf = n_sf;
        pc = n_pc; imm = n_imm; funct3 = n_f3;
        is_branch = n_br; is_jal = n_jal; is_jalr = n_jalr;
        rd = n_rd; reg_write = n_rw; mem_read = n_mr; mem_write = n_mw; store_data = n_store;
        in_valid = iv; out_ready = ordy; flush_in = fl;
        #1;
        rdy_exp = (exp_q.size() == 0) || ordy;
        check_eq("in_ready", W'(in_ready), W'(rdy_exp));
        exp_redirect = 1'b0;
        exp_illegal  = 1'b0;
        if (fl) begin
            exp_q.delete();
            skip = 0;
        end else begin
            if (exp_q.size() != 0 && ordy) void'(exp_q.pop_front());
            if (iv && rdy_exp) begin
                if (skip > 0) begin
                    skip--;
                end else begin
                    exp_q.push_back(ref_word());
                    exp_illegal = ref_illegal();
                    if (ref_taken()) begin
                        exp_redirect = 1'b1;
                        exp_rpc      = ref_target();
                        skip         = DEPTH;
                    end
                end
            end
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        skip         = 0;
        exp_redirect = 1'b0;
        exp_illegal  = 1'b0;
        exp_rpc      = 32'd0;
    endtask

    task automatic idle_inputs();
        in_valid = 1'b0; out_ready = 1'b1; flush_in = 1'b0;
        alu_r = '0; {alu_cf, alu_zf, alu_vf, alu_sf} = 4'd0;
        pc = '0; imm = '0; funct3 = 3'd0;
        is_branch = 1'b0; is_jal = 1'b0; is_jalr = 1'b0;
        rd = 5'd0; reg_write = 1'b0; mem_read = 1'b0; mem_write = 1'b0; store_data = '0;
    endtask

    initial begin
        logic [31:0] r;
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b0;
        idle_inputs();
        model_reset();
        set_alu(32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;

        // reset state
        cycle(0, 1, 0);

        // BEQ taken, two younger instructions dropped, third registers
        set_branch(32'h100, 32'h20, 32'd5, 32'd5, BR_BEQ); cycle(1, 1, 0);
        set_alu(32'hA1);  cycle(1, 1, 0);
        set_alu(32'hA2);  cycle(1, 1, 0);
        set_alu(32'hA3);  cycle(1, 1, 0);
        cycle(0, 1, 0);

        // BLTU not taken, BLT taken on rs1=-1, rs2=1
        set_branch(32'h200, 32'h40, 32'hFFFF_FFFF, 32'd1, BR_BLTU); cycle(1, 1, 0);
        set_branch(32'h204, 32'h40, 32'hFFFF_FFFF, 32'd1, BR_BLT);  cycle(1, 1, 0);
        set_alu(32'hB1); cycle(1, 1, 0);
        set_alu(32'hB2); cycle(1, 1, 0);

        // JALR with link wrap
        set_jalr(32'hFFFF_FFFC, 32'h0000_1003); cycle(1, 1, 0);
        set_alu(32'hC1); cycle(1, 1, 0);
        set_alu(32'hC2); cycle(1, 1, 0);
        cycle(0, 1, 0);

        // backpressure: hold three cycles, then release
        set_alu(32'hD1); cycle(1, 1, 0);
        set_alu(32'hD2);
        repeat (3) cycle(1, 0, 0);
        cycle(1, 1, 0);
        cycle(0, 1, 0);

        // flush during squash with one discard left
        set_jal(32'h300, 32'h10); cycle(1, 1, 0);
        set_alu(32'hE1); cycle(1, 1, 0);
        set_alu(32'hE2); cycle(1, 1, 1);
        set_alu(32'hE3); cycle(1, 1, 0);
        cycle(0, 1, 0);

        // reserved branch encoding with reg_write requested
        set_branch(32'h400, 32'h8, 32'd3, 32'd3, BR_RSV2); n_rw = 1'b1; cycle(1, 1, 0);
        cycle(0, 1, 0);

        // asynchronous reset in the middle of a squash
        set_jal(32'h500, 32'h80); cycle(1, 1, 0);
        @(negedge clk);
        #2;
        check_eq("pre_rst_valid", W'(out_valid), W'(exp_q.size() != 0));
        check_eq("pre_rst_cnt", W'(dbg_cnt), W'(skip));
        rst = 1'b0;
        in_valid = 1'b0;
        #1;
        check_eq("rst_valid", W'(out_valid), W'(0));
        check_eq("rst_redirect", W'({redirect_valid, illegal_branch}), W'(0));
        check_eq("rst_rpc", W'(redirect_pc), W'(0));
        check_eq("rst_data", {out_result, out_store_data, out_rd, out_reg_write, out_mem_read, out_mem_write}, W'(0));
        check_eq("rst_cnt", W'({dbg_state == SQUASH, dbg_cnt}), W'(0));
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        set_alu(32'hF0); cycle(1, 1, 0);

        // random traffic
        for (int i = 0; i < 600; i++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3: begin
                    r = $urandom;
                    if ($urandom_range(0, 3) == 0)      r = 32'd0;
                    set_branch({$urandom, 2'b00} >> 0, {{20{r[11]}}, r[11:0]},
                               $urandom, ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom, 3'($urandom));
                    if ($urandom_range(0, 3) == 0) n_rs2 = n_rs1;
                    set_branch(n_pc, n_imm, n_rs1, n_rs2, n_f3);
                end
                4:       set_jal({$urandom_range(0, 1) ? 30'h3FFF_FFFF : 30'($urandom), 2'b00}, $urandom);
                5:       set_jalr({30'($urandom), 2'b00}, $urandom);
                default: set_alu($urandom);
            endcase
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 24) == 0);
        end
        cycle(0, 1, 0);
        cycle(0, 1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
